// File: rtl/exc_ctrl_if.sv
// Decode/fetch-side signals of the exception sequencer, bundled for exc_ctrl.
// The master side is the pipeline (drives decode status); the slave side is exc_ctrl.
interface exc_ctrl_if;
  logic        irq_async;
  logic [31:0] pc_decode;
  logic        dec_valid;
  logic        op_ill;
  logic        stall;
  logic        exc_inject;
  logic        exc_annul_f;
  logic        exc_pc_sel;
  logic [31:0] exc_vec;
  logic [1:0]  exc_cause;
  logic        irq_ack;
  logic        busy;
  logic [15:0] ill_count;

  modport master (
    output irq_async, pc_decode, dec_valid, op_ill, stall,
    input  exc_inject, exc_annul_f, exc_pc_sel, exc_vec, exc_cause,
           irq_ack, busy, ill_count
  );

  modport slave (
    input  irq_async, pc_decode, dec_valid, op_ill, stall,
    output exc_inject, exc_annul_f, exc_pc_sel, exc_vec, exc_cause,
           irq_ack, busy, ill_count
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer for the Beta pipeline: injects BNE-to-XP in decode,
// redirects fetch to the vector, then holds off further exceptions until write-back.
module exc_ctrl #(
  parameter logic [31:0] ILLOP_VEC    = 32'h8000_0004,
  parameter logic [31:0] IRQ_VEC      = 32'h8000_0008,
  parameter int          DRAIN_CYCLES = 3,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic      clk,
  input  logic      rst,
  exc_ctrl_if.slave bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   irq_prev_q;
  logic                   irq_pend_q, irq_pend_d;
  logic [1:0]             cause_q, cause_d;
  logic [15:0]            ill_cnt_q, ill_cnt_d;

  logic irq_s;
  logic irq_rise;
  logic can_take;
  logic take_ill;
  logic take_irq;
  logic unused_pc;

  assign irq_s     = sync_q[SYNC_STAGES-1];
  assign irq_rise  = irq_s && !irq_prev_q;
  assign unused_pc = ^bus.pc_decode[30:0];

  // rst gating keeps every Mealy output low while reset is asserted
  assign can_take = !rst && (state_q == IDLE) && bus.dec_valid && !bus.stall;
  assign take_ill = can_take && bus.op_ill;
  assign take_irq = can_take && irq_pend_q && !bus.pc_decode[31] && !bus.op_ill;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (take_ill || take_irq) begin
          state_d = DRAIN;
          cnt_d   = CNT_LOAD;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.exc_inject  = take_ill || take_irq;
    bus.exc_annul_f = take_ill || take_irq;
    bus.exc_pc_sel  = take_ill || take_irq;
    bus.exc_vec     = take_ill ? ILLOP_VEC : (take_irq ? IRQ_VEC : 32'h0);
    bus.irq_ack     = take_irq;
    bus.busy        = (state_q == DRAIN);
    bus.exc_cause   = cause_q;
    bus.ill_count   = ill_cnt_q;
  end

  // Accept clears the pending request even if a new edge arrives in the same cycle
  always_comb begin
    irq_pend_d = irq_pend_q;
    if (take_irq)      irq_pend_d = 1'b0;
    else if (irq_rise) irq_pend_d = 1'b1;

    cause_d = cause_q;
    if (take_ill)      cause_d = 2'b01;
    else if (take_irq) cause_d = 2'b10;

    ill_cnt_d = ill_cnt_q;
    if (take_ill && (ill_cnt_q != 16'hFFFF)) ill_cnt_d = ill_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      irq_prev_q <= 1'b0;
      irq_pend_q <= 1'b0;
      cause_q    <= 2'b00;
      ill_cnt_q  <= 16'h0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.irq_async};
      irq_prev_q <= irq_s;
      irq_pend_q <= irq_pend_d;
      cause_q    <= cause_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: each driven cycle queues its expected outputs,
// which are popped and compared mid-cycle on the falling clock edge.
module tb_exc_ctrl;

  localparam logic [31:0] ILLOP = 32'h8000_0004;
  localparam logic [31:0] IRQV  = 32'h8000_0008;
  localparam int EV_N = 0;
  localparam int EV_I = 1;
  localparam int EV_Q = 2;

  typedef struct {
    string       tag;
    logic        act;
    logic [31:0] vec;
    logic        ack;
    logic        busy;
    logic [1:0]  cause;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  exp_t sb[$];

  exc_ctrl_if bus();

  exc_ctrl #(
    .ILLOP_VEC   (ILLOP),
    .IRQ_VEC     (IRQV),
    .DRAIN_CYCLES(3),
    .SYNC_STAGES (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One pipeline cycle: drive inputs just after the rising edge, queue expectations
  task automatic cyc(input string tag, input logic r, input logic dv, input logic ill,
                     input logic stl, input logic irq, input logic [31:0] pc,
                     input int ev, input logic eb, input logic [1:0] ec,
                     input logic [15:0] en);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    bus.dec_valid = dv;
    bus.op_ill    = ill;
    bus.stall     = stl;
    bus.irq_async = irq;
    bus.pc_decode = pc;
    e.tag   = tag;
    e.act   = (ev != EV_N);
    e.vec   = (ev == EV_I) ? ILLOP : ((ev == EV_Q) ? IRQV : 32'h0);
    e.ack   = (ev == EV_Q);
    e.busy  = eb;
    e.cause = ec;
    e.cnt   = en;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, ".inject"}, 32'(bus.exc_inject),  32'(e.act));
        chk({e.tag, ".annul"},  32'(bus.exc_annul_f), 32'(e.act));
        chk({e.tag, ".pcsel"},  32'(bus.exc_pc_sel),  32'(e.act));
        chk({e.tag, ".vec"},    bus.exc_vec,          e.vec);
        chk({e.tag, ".ack"},    32'(bus.irq_ack),     32'(e.ack));
        chk({e.tag, ".busy"},   32'(bus.busy),        32'(e.busy));
        chk({e.tag, ".cause"},  32'(bus.exc_cause),   32'(e.cause));
        chk({e.tag, ".count"},  32'(bus.ill_count),   32'(e.cnt));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.irq_async = 1'b0;
    bus.pc_decode = 32'h0;
    bus.dec_valid = 1'b0;
    bus.op_ill    = 1'b0;
    bus.stall     = 1'b0;

    // Reset: accept condition present but everything must stay low
    repeat (2) cyc("rst", 1, 1, 1, 0, 0, 32'h100, EV_N, 0, 2'd0, 16'd0);

    // Illegal opcode, then DRAIN ignores a live accept condition
    cyc("ill_acc", 0, 1, 1, 0, 0, 32'h100, EV_I, 0, 2'd0, 16'd0);
    repeat (3) cyc("ill_drn", 0, 1, 1, 0, 0, 32'h100, EV_N, 1, 2'd1, 16'd1);
    cyc("ill_idle", 0, 0, 0, 0, 0, 32'h100, EV_N, 0, 2'd1, 16'd1);

    // One-cycle irq pulse: two sync stages plus edge detect before accept
    cyc("irq_sync", 0, 1, 0, 0, 1, 32'h200, EV_N, 0, 2'd1, 16'd1);
    repeat (2) cyc("irq_sync", 0, 1, 0, 0, 0, 32'h200, EV_N, 0, 2'd1, 16'd1);
    cyc("irq_acc", 0, 1, 0, 0, 0, 32'h200, EV_Q, 0, 2'd1, 16'd1);
    repeat (3) cyc("irq_drn", 0, 1, 0, 0, 0, 32'h200, EV_N, 1, 2'd2, 16'd1);
    cyc("irq_once", 0, 1, 0, 0, 0, 32'h200, EV_N, 0, 2'd2, 16'd1);

    // Supervisor mode holds the interrupt pending
    repeat (10) cyc("sup_hold", 0, 1, 0, 0, 1, 32'h8000_0010, EV_N, 0, 2'd2, 16'd1);
    cyc("sup_user", 0, 1, 0, 0, 1, 32'h0000_0020, EV_Q, 0, 2'd2, 16'd1);
    repeat (3) cyc("sup_drn", 0, 1, 0, 0, 0, 32'h20, EV_N, 1, 2'd2, 16'd1);
    cyc("sup_clr", 0, 1, 0, 0, 0, 32'h20, EV_N, 0, 2'd2, 16'd1);

    // Stalled illegal opcode taken on the first unstalled cycle
    repeat (2) cyc("stall", 0, 1, 1, 1, 0, 32'h300, EV_N, 0, 2'd2, 16'd1);
    cyc("stall_rel", 0, 1, 1, 0, 0, 32'h300, EV_I, 0, 2'd2, 16'd1);
    repeat (3) cyc("stall_drn", 0, 0, 0, 0, 0, 32'h300, EV_N, 1, 2'd1, 16'd2);

    // Illegal opcode and pending interrupt together; bubbles never accepted
    cyc("pri_sync", 0, 0, 1, 0, 1, 32'h300, EV_N, 0, 2'd1, 16'd2);
    repeat (2) cyc("pri_sync", 0, 0, 1, 0, 0, 32'h300, EV_N, 0, 2'd1, 16'd2);
    cyc("pri_bubble", 0, 0, 1, 0, 0, 32'h300, EV_N, 0, 2'd1, 16'd2);
    cyc("pri_ill", 0, 1, 1, 0, 0, 32'h300, EV_I, 0, 2'd1, 16'd2);
    repeat (3) cyc("pri_drn", 0, 1, 0, 0, 0, 32'h300, EV_N, 1, 2'd1, 16'd3);
    cyc("pri_irq", 0, 1, 0, 0, 0, 32'h300, EV_Q, 0, 2'd1, 16'd3);
    repeat (3) cyc("pri_irq_drn", 0, 0, 0, 0, 0, 32'h300, EV_N, 1, 2'd2, 16'd3);
    cyc("pri_idle", 0, 0, 0, 0, 0, 32'h300, EV_N, 0, 2'd2, 16'd3);

    // Saturation of the illegal-opcode counter
    @(negedge clk);
    #1 force dut.ill_cnt_q = 16'hFFFE;
    #1 release dut.ill_cnt_q;
    for (int k = 0; k < 3; k++) begin
      cyc("sat_acc", 0, 1, 1, 0, 0, 32'h400, EV_I, 0, (k == 0) ? 2'd2 : 2'd1,
          (k == 0) ? 16'hFFFE : 16'hFFFF);
      repeat (3) cyc("sat_drn", 0, 0, 0, 0, 0, 32'h400, EV_N, 1, 2'd1, 16'hFFFF);
    end
    cyc("sat_idle", 0, 0, 0, 0, 0, 32'h400, EV_N, 0, 2'd1, 16'hFFFF);

    // Reset asserted in DRAIN takes effect immediately
    cyc("rd_acc", 0, 1, 1, 0, 0, 32'h500, EV_I, 0, 2'd1, 16'hFFFF);
    repeat (2) cyc("rd_rst", 1, 1, 1, 0, 0, 32'h500, EV_N, 0, 2'd0, 16'd0);
    cyc("rd_post", 0, 0, 0, 0, 0, 32'h500, EV_N, 0, 2'd0, 16'd0);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception and interrupt sequencer for the 5-stage Beta pipeline.
- Watches the instruction held in decode and decides when to replace it with the exception branch (BNE R31 into XP).
- Same cycle as that decision: redirects fetch to the matching vector and annuls the fetched instruction.
- Blocks further exceptions until the injected instruction has drained to write-back; synchronises the external interrupt line and tracks an illegal-opcode statistic.

Parameters:
- ILLOP_VEC, 32'h80000004, fetch target for an illegal opcode.
- IRQ_VEC, 32'h80000008, fetch target for an external interrupt.
- DRAIN_CYCLES, 3, cycles spent in DRAIN after an injection (decode to write-back distance).
- SYNC_STAGES, 2, flip-flop depth of the irq synchroniser (minimum 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- irq_async  in  1  external interrupt request; asynchronous, level
- pc_decode  in  32  PC+4 of the instruction in decode; bit 31 is the supervisor bit
- dec_valid  in  1  decode holds a real instruction (not a NOP bubble)
- op_ill  in  1  decode opcode is illegal
- stall  in  1  decode load-use stall
- exc_inject  out  1  decode substitutes INST_BNE_EXCEPT for ir_next
- exc_annul_f  out  1  fetch turns the instruction it is passing to decode into INST_NOP
- exc_pc_sel  out  1  fetch PC mux selects exc_vec; overrides branch and jump targets
- exc_vec  out  32  vector address, valid while exc_pc_sel=1
- exc_cause  out  2  00 none, 01 illegal opcode, 10 interrupt; registered, held until the next accept
- irq_ack  out  1  one-cycle pulse when an interrupt is accepted
- busy  out  1  high in DRAIN
- ill_count  out  16  saturating count of illegal-opcode exceptions taken

Behaviour:
- Reset values (asynchronous): state IDLE, synchroniser chain 0, irq_pend 0, drain counter 0, exc_cause 00, ill_count 0. All combinational outputs (exc_inject, exc_annul_f, exc_pc_sel, irq_ack) are 0 while rst=1. exc_vec is 0 whenever exc_pc_sel=0.
- Synchroniser: irq_async passes through SYNC_STAGES flops, giving irq_s.
  - A rising edge of irq_s (irq_s=1 while its previous value was 0) sets irq_pend.
  - irq_pend clears only on interrupt accept or on reset.
  - If the edge and the accept fall in the same cycle, the accept wins: only one request is recorded.
- Accept condition in IDLE: dec_valid && !stall, plus one of:
  - take_ill = op_ill;
  - take_irq = irq_pend && !pc_decode[31] && !op_ill.
- Priority: illegal opcode over interrupt. In supervisor mode (pc_decode[31]=1) interrupts stay pending; illegal opcodes are still taken.
- Accept cycle (Mealy, same cycle as the condition):
  - exc_inject=1, exc_annul_f=1, exc_pc_sel=1.
  - exc_vec = ILLOP_VEC for take_ill, IRQ_VEC for take_irq.
  - irq_ack=1 only for take_irq.
  - At the clock edge: exc_cause is registered (01 or 10), irq_pend is cleared if take_irq, ill_count increments if take_ill (held at 16'hFFFF once there), state goes to DRAIN, drain counter loads DRAIN_CYCLES-1.
- DRAIN:
  - busy=1; no accept, even when the accept condition is true.
  - The counter decrements each cycle; state returns to IDLE on the edge where it is 0.
  - DRAIN therefore lasts exactly DRAIN_CYCLES cycles; with DRAIN_CYCLES=1 it lasts a single cycle.
  - irq_pend may still be set during DRAIN and is serviced afterwards.
- Stall: no accept while stall=1. The condition is re-evaluated every cycle, so an illegal opcode held in decode by a stall is accepted in the first cycle with stall=0.
- Bubbles: with dec_valid=0 nothing is accepted, so an exception is never attached to a NOP.
- Simultaneous fetch redirect: if decode holds a taken branch or jump in the accept cycle, exc_pc_sel overrides it. The branch is discarded because decode forwards the exception instruction in its place.
- Reset during DRAIN: state returns to IDLE immediately, pending interrupt is lost, no outputs glitch high.

Test Plan:
- Reset, then pc_decode=0x00000100, dec_valid=1, op_ill=1, stall=0 -> same cycle exc_inject=exc_annul_f=exc_pc_sel=1, exc_vec=0x80000004; next cycle exc_cause=01, ill_count=1, busy=1 for 3 cycles, then IDLE.
- Pulse irq_async high for 1 cycle with pc_decode=0x00000200, dec_valid=1 -> accept exactly 3 cycles later (2 sync stages + edge detect): exc_vec=0x80000008, irq_ack pulses once, exc_cause=10.
- irq pending with pc_decode=0x80000010 for 10 cycles -> no accept; pc_decode changes to 0x00000020 -> accept in that cycle.
- op_ill=1 together with stall=1 for 2 cycles, then stall=0 -> no outputs during the stall, accept on the third cycle; op_ill=1 and irq_pend=1 together -> ILLOP taken first, IRQ taken in the first valid cycle after DRAIN.
- Force ill_count to 16'hFFFE, then take 3 illegal opcodes -> count reads FFFF and stays there; assert rst during DRAIN -> busy=0 and exc_cause=00 immediately.
